// File: rtl/uart_peer.sv
// uart_peer: far-end UART initiator that sends operands A and B as 8N1 frames, then receives a one-byte result.
// Define UART_PEER_TIMEOUT_EN to build the response-start timeout; otherwise WAIT_RSP waits indefinitely.
module uart_peer #(
   parameter int BAUD_DIV     = 651,
   parameter int TIMEOUT_BITS = 200
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       req_valid,
   input  logic [7:0] req_a,
   input  logic [7:0] req_b,
   output logic       req_ready,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_ferr,
   output logic       rsp_timeout,
   output logic       busy,
   output logic       uart_tx,
   input  logic       uart_rx
);
   localparam int TW = $clog2(BAUD_DIV + 1);
   typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_RSP, RECV} state_t;
   state_t        r_state;
   logic [TW-1:0] r_div;
   logic [19:0]   r_frame;
   logic [4:0]    r_tbit;
   logic [3:0]    r_tcnt;
   logic          r_rx1;
   logic          r_rx2;
   logic          r_sdet;
   logic [3:0]    r_rcnt;
   logic [3:0]    r_rbit;
   logic [7:0]    r_rsr;
   logic          w_tick;
   logic          w_to_hit;
   logic          w_confirm;

   assign w_tick    = r_div == TW'(BAUD_DIV - 1);
   assign req_ready = r_state == IDLE && !reset;
   assign busy      = r_state != IDLE;
   assign w_confirm = r_sdet && r_rcnt == 4'd7 && !r_rx2;

`ifdef UART_PEER_TIMEOUT_EN
   localparam int TO_TICKS = TIMEOUT_BITS * 16;
   localparam int CW = $clog2(TO_TICKS + 1);
   logic [CW-1:0] r_to_cnt;
   assign w_to_hit = w_tick && r_to_cnt == CW'(TO_TICKS - 1);
   always_ff @(posedge sysclk)
      if (reset || r_state != WAIT_RSP) r_to_cnt <= '0;
      else if (w_tick) r_to_cnt <= r_to_cnt + 1'b1;
`else
   logic w_unused;
   assign w_unused = |TIMEOUT_BITS;
   assign w_to_hit = 1'b0;
`endif

   always_ff @(posedge sysclk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_div       <= '0;
         r_frame     <= '0;
         r_tbit      <= '0;
         r_tcnt      <= '0;
         r_rx1       <= 1'b1;
         r_rx2       <= 1'b1;
         r_sdet      <= 1'b0;
         r_rcnt      <= '0;
         r_rbit      <= '0;
         r_rsr       <= '0;
         uart_tx     <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_ferr    <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         r_div       <= w_tick ? '0 : r_div + 1'b1;
         r_rx1       <= uart_rx;
         r_rx2       <= r_rx1;
         rsp_valid   <= 1'b0;
         rsp_timeout <= 1'b0;
         case (r_state)
            IDLE: if (req_valid) begin
               // both frames back to back: start, A LSB first, stop, start, B, stop
               r_frame <= {1'b1, req_b, 2'b01, req_a, 1'b0};
               r_tbit  <= '0;
               r_tcnt  <= '0;
               r_state <= SEND_A;
            end
            SEND_A, SEND_B: if (w_tick) begin
               if (r_tcnt == 4'd0) uart_tx <= r_frame[r_tbit];
               r_tcnt <= r_tcnt + 1'b1;
               if (r_tcnt == 4'd15) begin
                  r_tbit <= r_tbit + 1'b1;
                  if (r_tbit == 5'd9) r_state <= SEND_B;
                  if (r_tbit == 5'd19) begin
                     r_state <= WAIT_RSP;
                     r_sdet  <= 1'b0;
                  end
               end
            end
            WAIT_RSP: if (w_tick) begin
               r_sdet <= r_sdet ? r_rcnt != 4'd7 : !r_rx2;
               r_rcnt <= r_sdet && r_rcnt != 4'd7 ? r_rcnt + 1'b1 : '0;
               r_rbit <= '0;
               if (w_confirm) r_state <= RECV;
               else if (w_to_hit) begin
                  r_state     <= IDLE;
                  rsp_timeout <= 1'b1;
               end
            end
            RECV: if (w_tick) begin
               r_rcnt <= r_rcnt + 1'b1;
               if (r_rcnt == 4'd15) begin
                  r_rbit <= r_rbit + 1'b1;
                  if (r_rbit == 4'd8) begin
                     rsp_valid <= 1'b1;
                     rsp_data  <= r_rsr;
                     rsp_ferr  <= !r_rx2;
                     r_state   <= IDLE;
                  end else r_rsr <= {r_rx2, r_rsr[7:1]};
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_peer.sv
// tb_uart_peer: directed bench for uart_peer with tx-bit and response scoreboards.
module tb_uart_peer;
   logic       sysclk = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic [7:0] req_a = '0;
   logic [7:0] req_b = '0;
   logic       req_ready;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_ferr;
   logic       rsp_timeout;
   logic       busy;
   logic       uart_tx;
   logic       uart_rx = 1'b1;

   int         errors = 0;
   int         checks = 0;
   int         nrsp = 0;
   int         n;
   logic       txq[$];
   logic [8:0] rspq[$];
   logic [8:0] rsp_exp;

   uart_peer #(.BAUD_DIV(4), .TIMEOUT_BITS(20)) dut (
      .sysclk(sysclk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ferr(rsp_ferr),
      .rsp_timeout(rsp_timeout), .busy(busy), .uart_tx(uart_tx), .uart_rx(uart_rx)
   );

   always #5 sysclk = ~sysclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int c);
      repeat (c) @(negedge sysclk);
   endtask

   task automatic wait_tx_start();
      int k = 0;
      while (uart_tx !== 1'b0 && k < 400) begin
         step(1);
         k++;
      end
      chk("tx_start_seen", uart_tx, 0);
   endtask

   // Returns half a bit after the B stop bit, i.e. a few cycles into WAIT_RSP.
   task automatic send_req(input logic [7:0] a, input logic [7:0] b);
      txq.push_back(1'b0);
      for (int i = 0; i < 8; i++) txq.push_back(a[i]);
      txq.push_back(1'b1);
      txq.push_back(1'b0);
      for (int i = 0; i < 8; i++) txq.push_back(b[i]);
      txq.push_back(1'b1);
      req_a = a;
      req_b = b;
      req_valid = 1'b1;
      step(1);
      req_valid = 1'b0;
      chk("busy_after_accept", busy, 1);
      chk("ready_after_accept", req_ready, 0);
      wait_tx_start();
      for (int i = 0; i < 20; i++) begin
         step(i == 0 ? 32 : 64);
         chk($sformatf("tx_bit%0d", i), uart_tx, txq.pop_front());
         chk($sformatf("busy_bit%0d", i), busy, 1);
      end
      step(32);
      chk("busy_wait_rsp", busy, 1);
   endtask

   task automatic drive_rx(input logic [7:0] d, input logic stop);
      uart_rx = 1'b0;
      step(64);
      for (int i = 0; i < 8; i++) begin
         uart_rx = d[i];
         step(64);
      end
      uart_rx = stop;
      step(64);
      uart_rx = 1'b1;
      step(64);
   endtask

   always @(negedge sysclk) begin
      if (rsp_valid === 1'b1) begin
         nrsp++;
         chk("rsp_expected", rspq.size() != 0, 1);
         if (rspq.size() != 0) begin
            rsp_exp = rspq.pop_front();
            chk("rsp_data", rsp_data, rsp_exp[7:0]);
            chk("rsp_ferr", rsp_ferr, rsp_exp[8]);
            chk("rsp_ready", req_ready, 1);
            chk("rsp_busy", busy, 0);
         end
      end
   end

   initial begin
      step(5);
      chk("rst_tx", uart_tx, 1);
      chk("rst_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_timeout", rsp_timeout, 0);
      chk("rst_ferr", rsp_ferr, 0);
      chk("rst_data", rsp_data, 8'h00);
      reset = 1'b0;
      step(1);
      chk("ready_after_reset", req_ready, 1);

      // good response
      send_req(8'h35, 8'hA6);
      step(3 * 64);
      rspq.push_back({1'b0, 8'h5B});
      drive_rx(8'h5B, 1'b1);
      chk("rsp_count1", nrsp, 1);
      chk("ready_after_rsp", req_ready, 1);
      chk("data_held", rsp_data, 8'h5B);

      // framing error
      send_req(8'h12, 8'h34);
      step(64);
      rspq.push_back({1'b1, 8'hC3});
      drive_rx(8'hC3, 1'b0);
      chk("rsp_count2", nrsp, 2);
      chk("ferr_held", rsp_ferr, 1);

      // glitch in WAIT_RSP, then timeout
      send_req(8'hF0, 8'h0F);
      uart_rx = 1'b0;
      step(8);
      uart_rx = 1'b1;
`ifdef UART_PEER_TIMEOUT_EN
      n = 0;
      while (rsp_timeout !== 1'b1 && n < 2000) begin
         step(1);
         n++;
      end
      chk("timeout_latency", n, 1268);
      chk("timeout_idle", busy, 0);
      step(1);
      chk("timeout_pulse", rsp_timeout, 0);
      chk("ready_after_timeout", req_ready, 1);
      chk("rsp_count_glitch", nrsp, 2);
`else
      step(1400);
      chk("wait_forever_busy", busy, 1);
      chk("no_timeout", rsp_timeout, 0);
      chk("rsp_count_glitch", nrsp, 2);
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(1);
`endif

      // reset during bit 4 of A (A bit 3 = 0)
      req_a = 8'h35;
      req_b = 8'hA6;
      req_valid = 1'b1;
      step(1);
      req_valid = 1'b0;
      wait_tx_start();
      step(32 + 4 * 64);
      chk("tx_before_reset", uart_tx, 0);
      reset = 1'b1;
      step(1);
      chk("tx_after_reset", uart_tx, 1);
      chk("busy_after_reset", busy, 0);
      chk("ready_in_reset", req_ready, 0);
      reset = 1'b0;
      step(1);
      chk("ready_after_reset2", req_ready, 1);
      send_req(8'h01, 8'h02);
      step(64);
      rspq.push_back({1'b0, 8'h5A});
      drive_rx(8'h5A, 1'b1);
      chk("rsp_count3", nrsp, 3);

      // data during SEND_B is ignored
      fork
         send_req(8'hAA, 8'h55);
         begin
            wait_tx_start();
            step(650);
            drive_rx(8'h77, 1'b1);
         end
      join
      chk("busy_before_rsp", busy, 1);
      rspq.push_back({1'b0, 8'h11});
      drive_rx(8'h11, 1'b1);
      chk("rsp_count4", nrsp, 4);
      chk("data_held_11", rsp_data, 8'h11);
      chk("rsp_queue_empty", rspq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
